benes_cfg_scheduler: RTL and testbench
======================================

Name: benes_cfg_scheduler

Overview:
Time-division configuration scheduler for the 8x8 Benes network_module (5 stages x 4 two-by-two switches, bit=1 cross, bit=0 bar).
- Holds up to N_SLOTS complete switch configurations written by a host over a valid/ready port.
- When running, drives network_module's switch_set from the slots in round-robin order. Each slot gets a settle interval followed by a programmable hold interval.
- Flags the cycles in which the routing is stable, so producers on i_port only launch data when the permutation is guaranteed.

Parameters:
N_STAGES, 5, Benes stages (2*log2(8)-1)
SW_PER_STAGE, 4, switches per stage (8/2)
N_SLOTS, 4, configuration slots; power of two, >=2
HOLD_W, 8, width of hold counter
SETTLE, 1, cycles with cfg_stable low after each new configuration is applied; 0 allowed

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
wr_valid  in  1  host write request
wr_ready  out  1  write accepted when wr_valid and wr_ready both high at a clk edge
wr_slot  in  log2(N_SLOTS)  target slot
wr_stage  in  3  target stage, 0..N_STAGES-1
wr_bits  in  SW_PER_STAGE  switch settings for that stage
run_en  in  1  level; 1 = schedule runs, 0 = stop
num_slots_m1  in  log2(N_SLOTS)  last slot index in the rotation
hold_cycles  in  HOLD_W  cycles each slot is held stable; 0 is treated as 1
switch_set  out  [SW_PER_STAGE-1:0] x [N_STAGES-1:0] (unpacked)  to network_module
cur_slot  out  log2(N_SLOTS)  slot currently driven
slot_start  out  1  one-cycle pulse in the first cycle a new slot is driven
cfg_stable  out  1  switch_set is settled; data may be launched
err_wr  out  1  one-cycle pulse: accepted write had wr_stage >= N_STAGES (write dropped)

Behaviour:
- Reset (rst_n=0 at an edge): all table entries = 0 (all bar); switch_set = 0; cur_slot = 0; state = IDLE; slot_start, cfg_stable, err_wr = 0. Reset mid-run aborts immediately; table contents are lost.
- States:
  - IDLE -> LOAD when run_en=1.
  - LOAD (1 cycle) -> SETTLE if SETTLE>0, else HOLD.
  - SETTLE (SETTLE cycles) -> HOLD.
  - HOLD (max(hold_cycles,1) cycles) -> LOAD with next slot.
  - Any non-IDLE state -> IDLE when run_en=0 is sampled, taking priority over all other transitions.
- Entry into LOAD:
  - From IDLE: cur_slot <= 0.
  - From HOLD: cur_slot <= (cur_slot==num_slots_m1) ? 0 : cur_slot+1.
  - If num_slots_m1 is changed below cur_slot, the next slot is 0.
- During LOAD:
  - switch_set <= table[cur_slot], registered, so visible from the cycle after LOAD.
  - slot_start = 1 in the first cycle switch_set holds the new value.
  - hold_cycles is sampled into the hold counter; num_slots_m1 is read at each HOLD->LOAD transition.
- cfg_stable: 1 exactly in HOLD cycles, 0 otherwise.
  - Latency from run_en sampled high in IDLE to first cfg_stable=1 = 2+SETTLE cycles.
- Stop (run_en=0): switch_set and cur_slot keep their last values in IDLE. cfg_stable drops the cycle after run_en=0 is sampled.
- Write handshake:
  - wr_ready = 1 in IDLE.
  - Outside IDLE, wr_ready = (wr_slot != cur_slot); writes to the slot being driven are stalled, not dropped.
  - wr_ready does not depend on wr_valid. wr_ready is combinational from wr_slot, state and cur_slot.
  - An accepted write updates table[wr_slot][wr_stage] at that edge.
  - A write accepted in the last HOLD cycle to the next slot is included in that slot's LOAD.
  - A write with wr_stage >= N_STAGES: accepted, table unchanged, err_wr = 1 the next cycle.
- switch_set only changes in the cycle after LOAD or on reset; it never glitches between slots.

Decomposition:
- benes_pkg:
  - Constants N_PORTS=8, N_STAGES=5, SW_PER_STAGE=4.
  - typedef sw_word_t = logic [SW_PER_STAGE-1:0].
  - typedef benes_cfg_t = sw_word_t [N_STAGES-1:0].
  - enum sched_state_t {IDLE, LOAD, SETTLE, HOLD}.
- Sub-module benes_cfg_table: N_SLOTS x benes_cfg_t register file with one stage-granular write port, one full-configuration read port, and synchronous clear on rst_n=0. The scheduler FSM, counters and handshake stay in the top module.

Test Plan:
- Reset then IDLE: switch_set all 0, cfg_stable=0, wr_ready=1; assert rst_n=0 mid-HOLD -> next cycle state IDLE, switch_set=0.
- Write slot0 = {4'b0010,4'b0110,4'b0110,4'b0101,4'b0101} (stages 0..4); num_slots_m1=0, hold=4, SETTLE=1, run_en=1 -> slot_start one cycle after LOAD, switch_set = slot0 values, cfg_stable high 4 cycles, low 2 cycles (LOAD+SETTLE), repeat. network_module with i_port[i]=i shows the expected permutation on o_port.
- Two slots (slot1 all 4'b1111), num_slots_m1=1, hold=3 -> cur_slot sequence 0,1,0,1; each slot_start aligned to a switch_set change; cfg_stable duty 3 of 5 cycles.
- While running on slot 1: write to slot1 -> wr_ready=0 until rotation moves to slot 0, then the write is accepted; a write to slot0 in the last HOLD cycle of slot1 is visible in the next LOAD.
- wr_stage=5 and 7 with wr_valid=1 -> accepted, err_wr pulses once each, table unchanged (readback via the next LOAD).
- hold_cycles=0 -> held 1 cycle; run_en dropped mid-SETTLE -> IDLE next cycle, cfg_stable stays 0, switch_set retained.

Source files
------------

// File: rtl/benes_pkg.sv
// Shared types and constants for the 8x8 Benes
// network and its configuration scheduler.
package benes_pkg;

  localparam int N_PORTS      = 8;
  localparam int N_STAGES     = 5;
  localparam int SW_PER_STAGE = 4;

  typedef logic [SW_PER_STAGE-1:0] sw_word_t;
  typedef sw_word_t [N_STAGES-1:0] benes_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    HOLD
  } sched_state_t;

endpackage

// File: rtl/benes_cfg_table.sv
// Slot register file: stage-granular write port,
// full-configuration read port, synchronous clear.
module benes_cfg_table
  import benes_pkg::*;
#(
  parameter int N_SLOTS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(N_SLOTS)-1:0] wr_slot,
  input  logic [2:0]                 wr_stage,
  input  sw_word_t                   wr_bits,
  input  logic [$clog2(N_SLOTS)-1:0] rd_slot,
  output benes_cfg_t                 rd_cfg
);

  benes_cfg_t mem [N_SLOTS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      // out-of-range stages match no entry
      for (int s = 0; s < N_STAGES; s++) begin
        if (wr_stage == 3'(s)) begin
          mem[wr_slot][s] <= wr_bits;
        end
      end
    end
  end

  assign rd_cfg = mem[rd_slot];

endmodule

// File: rtl/benes_cfg_scheduler.sv
// Round-robin time-division scheduler driving
// Benes switch_set from a table of slot configs.
module benes_cfg_scheduler
  import benes_pkg::N_STAGES,
         benes_pkg::SW_PER_STAGE,
         benes_pkg::benes_cfg_t,
         benes_pkg::sched_state_t,
         benes_pkg::IDLE,
         benes_pkg::LOAD,
         benes_pkg::HOLD;
#(
  parameter int N_SLOTS = 4,
  parameter int HOLD_W  = 8,
  parameter int SETTLE  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(N_SLOTS)-1:0] wr_slot,
  input  logic [2:0]                 wr_stage,
  input  logic [SW_PER_STAGE-1:0]    wr_bits,
  input  logic                       run_en,
  input  logic [$clog2(N_SLOTS)-1:0] num_slots_m1,
  input  logic [HOLD_W-1:0]          hold_cycles,
  output logic [SW_PER_STAGE-1:0]    switch_set [N_STAGES],
  output logic [$clog2(N_SLOTS)-1:0] cur_slot,
  output logic                       slot_start,
  output logic                       cfg_stable,
  output logic                       err_wr
);

  localparam int SLOT_W = $clog2(N_SLOTS);
  localparam int SET_W  = $clog2(SETTLE + 2);
  localparam sched_state_t ST_SETTLE =
    benes_pkg::SETTLE;

  sched_state_t      state;
  sched_state_t      state_d;
  logic [SET_W-1:0]  settle_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SLOT_W-1:0] next_slot;
  benes_cfg_t        rd_cfg;
  benes_cfg_t        sw_q;
  logic              wr_acc;
  logic              wr_bad;

  assign wr_acc = wr_valid & wr_ready;
  assign wr_bad = wr_stage >= 3'(N_STAGES);

  // shrinking num_slots_m1 below cur_slot wraps to 0
  assign next_slot =
    (cur_slot >= num_slots_m1) ? '0 :
    cur_slot + 1'b1;

  benes_cfg_table #(
    .N_SLOTS (N_SLOTS)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_acc & ~wr_bad),
    .wr_slot  (wr_slot),
    .wr_stage (wr_stage),
    .wr_bits  (wr_bits),
    .rd_slot  (cur_slot),
    .rd_cfg   (rd_cfg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (run_en) state_d = LOAD;
      end
      LOAD: begin
        state_d = (SETTLE > 0) ? ST_SETTLE : HOLD;
      end
      ST_SETTLE: begin
        if (settle_cnt <= SET_W'(1))
          state_d = HOLD;
      end
      HOLD: begin
        if (hold_cnt <= HOLD_W'(1))
          state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
    if (state != IDLE && !run_en) state_d = IDLE;
  end

  always_comb begin
    cfg_stable = (state == HOLD);
    wr_ready   = (state == IDLE) ||
                 (wr_slot != cur_slot);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_q       <= '0;
      cur_slot   <= '0;
      slot_start <= 1'b0;
      err_wr     <= 1'b0;
      settle_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      slot_start <= (state == LOAD);
      err_wr     <= wr_acc & wr_bad;
      if (state == LOAD) begin
        sw_q       <= rd_cfg;
        settle_cnt <= SET_W'(SETTLE);
        hold_cnt   <= (hold_cycles == '0) ?
                      HOLD_W'(1) : hold_cycles;
      end
      if (state == ST_SETTLE)
        settle_cnt <= settle_cnt - 1'b1;
      if (state == HOLD)
        hold_cnt <= hold_cnt - 1'b1;
      if (state_d == LOAD)
        cur_slot <= (state == IDLE) ? '0 : next_slot;
    end
  end

  always_comb begin
    for (int s = 0; s < N_STAGES; s++) begin
      switch_set[s] = sw_q[s];
    end
  end

endmodule

// File: tb/tb_benes_cfg_scheduler.sv
// Randomized bench for benes_cfg_scheduler with a
// slot-window reference model and directed checks.
module tb_benes_cfg_scheduler;

  localparam int NSL = 4;
  localparam int NST = 5;
  localparam int STL = 1;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_slot;
  logic [2:0] wr_stage;
  logic [3:0] wr_bits;
  logic       run_en;
  logic [1:0] num_slots_m1;
  logic [7:0] hold_cycles;
  logic [3:0] switch_set [NST];
  logic [1:0] cur_slot;
  logic       slot_start;
  logic       cfg_stable;
  logic       err_wr;

  benes_cfg_scheduler #(
    .N_SLOTS (NSL),
    .HOLD_W  (8),
    .SETTLE  (STL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_slot      (wr_slot),
    .wr_stage     (wr_stage),
    .wr_bits      (wr_bits),
    .run_en       (run_en),
    .num_slots_m1 (num_slots_m1),
    .hold_cycles  (hold_cycles),
    .switch_set   (switch_set),
    .cur_slot     (cur_slot),
    .slot_start   (slot_start),
    .cfg_stable   (cfg_stable),
    .err_wr       (err_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Model: a slot window is LOAD (age 0), SETTLE
  // cycles, then h hold cycles.
  logic [3:0] m_tab [NSL][NST];
  logic [3:0] m_sw [NST];
  bit m_run, m_ss, m_err, m_acc, model_ok;
  int m_age, m_h, m_cur;

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_tab[i, j]) m_tab[i][j] = '0;
      foreach (m_sw[j]) m_sw[j] = '0;
      m_run = 0; m_ss = 0; m_err = 0; m_acc = 0;
      m_age = 0; m_h = 1; m_cur = 0;
      model_ok = 1;
    end else begin
      bit acc, was_load;
      acc = wr_valid &&
            (!m_run || int'(wr_slot) != m_cur);
      was_load = m_run && m_age == 0;
      m_acc = acc;
      m_ss  = was_load;
      if (was_load)
        foreach (m_sw[j]) m_sw[j] = m_tab[m_cur][j];
      m_err = acc && wr_stage >= NST;
      if (!m_run) begin
        if (run_en) begin
          m_run = 1; m_age = 0; m_cur = 0;
        end
      end else if (!run_en) begin
        m_run = 0;
      end else if (m_age == 0) begin
        m_h = (hold_cycles == 0) ? 1 : hold_cycles;
        m_age = 1;
      end else if (m_age < STL + m_h) begin
        m_age++;
      end else begin
        m_age = 0;
        m_cur = (m_cur >= num_slots_m1) ? 0
                                        : m_cur + 1;
      end
      if (acc && wr_stage < NST)
        m_tab[wr_slot][wr_stage] = wr_bits;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int s = 0; s < NST; s++)
        chk($sformatf("sw%0d", s),
            switch_set[s], m_sw[s]);
      chk("cur_slot", cur_slot, m_cur);
      chk("slot_start", slot_start, m_ss);
      chk("cfg_stable", cfg_stable,
          m_run && m_age > STL);
      chk("err_wr", err_wr, m_err);
      chk("wr_ready", wr_ready,
          !m_run || int'(wr_slot) != m_cur);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(int sl, int st, int b);
    bit done;
    done = 0;
    wr_valid = 1; wr_slot = 2'(sl);
    wr_stage = 3'(st); wr_bits = 4'(b);
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (m_acc) done = 1;
    end
    wr_valid = 0;
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL write_timeout slot %0d", sl);
    end
  endtask

  task automatic wait_start();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (slot_start) seen = 1;
    end
    if (!seen) begin
      n_chk++; n_err++;
      $display("FAIL slot_start_timeout");
    end
  endtask

  logic [3:0] pat [NST];
  int cnt;

  initial begin
    pat[0] = 4'b0010; pat[1] = 4'b0110;
    pat[2] = 4'b0110; pat[3] = 4'b0101;
    pat[4] = 4'b0101;
    rst_n = 0; wr_valid = 0; wr_slot = 0;
    wr_stage = 0; wr_bits = 0; run_en = 0;
    num_slots_m1 = 0; hold_cycles = 4;
    tick(); tick();
    rst_n = 1;
    @(negedge clk);
    for (int s = 0; s < NST; s++)
      chk("rst_sw", switch_set[s], 0);
    chk("rst_stable", cfg_stable, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_cur", cur_slot, 0);

    for (int s = 0; s < NST; s++)
      do_write(0, s, pat[s]);
    run_en = 1;
    wait_start();
    for (int s = 0; s < NST; s++)
      chk("slot0_sw", switch_set[s], pat[s]);
    wr_slot = 0; #1;
    chk("stall_ready", wr_ready, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      cnt += int'(cfg_stable);
    end
    chk("duty4of6", cnt, 4);

    run_en = 0; tick(); tick();
    do_write(1, 5, 4'hF);
    @(negedge clk) chk("err5", err_wr, 1);
    @(negedge clk) chk("err5_once", err_wr, 0);
    do_write(1, 7, 4'hF);
    @(negedge clk) chk("err7", err_wr, 1);
    @(negedge clk) chk("err7_once", err_wr, 0);

    for (int s = 0; s < NST; s++)
      do_write(1, s, 4'hF);
    num_slots_m1 = 1; hold_cycles = 3;
    run_en = 1;
    for (int k = 0; k < 4; k++) begin
      wait_start();
      chk("rr_cur", cur_slot, k % 2);
      chk("rr_sw0", switch_set[0],
          (k % 2) ? 4'hF : pat[0]);
    end
    wr_valid = 1; wr_slot = 1; wr_stage = 0;
    wr_bits = 4'h3; #1;
    chk("stall_s1", wr_ready, 0);
    do_write(1, 0, 4'h3);
    cnt = 0;
    while (!(cfg_stable && cur_slot == 1) &&
           cnt < 40) begin
      @(negedge clk); cnt++;
    end
    chk("hold_s1_found", cnt < 40, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    for (int s = 0; s < NST; s++)
      chk("midrst_sw", switch_set[s], 0);
    chk("midrst_stable", cfg_stable, 0);
    chk("midrst_cur", cur_slot, 0);

    run_en = 0;
    do_write(0, 0, 4'hA);
    num_slots_m1 = 0; hold_cycles = 0;
    run_en = 1;
    wait_start();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      cnt += int'(cfg_stable);
    end
    chk("hold0_duty", cnt, 1);
    wait_start();
    run_en = 0;
    @(negedge clk);
    chk("stop_stable", cfg_stable, 0);
    chk("stop_sw0", switch_set[0], 4'hA);

    tick();
    for (int c = 0; c < 3000; c++) begin
      wr_valid = 1'($urandom);
      wr_slot  = 2'($urandom);
      wr_stage = 3'($urandom);
      wr_bits  = 4'($urandom);
      if (run_en && $urandom_range(49) == 0)
        run_en = 0;
      else if (!run_en && $urandom_range(7) == 0)
        run_en = 1;
      if ($urandom_range(39) == 0)
        num_slots_m1 = 2'($urandom);
      if ($urandom_range(19) == 0)
        hold_cycles = 8'($urandom_range(4));
      rst_n = ($urandom_range(399) != 0);
      tick();
    end
    rst_n = 1; wr_valid = 0; run_en = 0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
